// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle between the multicycle sequencer and the RV32 datapath.
interface multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic [6:0]       opCode;
  logic             zero;
  logic             INT;
  logic             memReady;
  logic             PCWrite;
  logic [1:0]       PCSel;
  logic             IRWrite;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             RegWrite;
  logic             ALUSrc;
  logic             Mem2Reg;
  logic [1:0]       ALUop;
  logic             trap;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opCode, zero, INT, memReady,
    output PCWrite, PCSel, IRWrite, IorD, MemRead, MemWrite, RegWrite,
           ALUSrc, Mem2Reg, ALUop, trap, state, instret
  );

  modport slave (
    output opCode, zero, INT, memReady,
    input  PCWrite, PCSel, IRWrite, IorD, MemRead, MemWrite, RegWrite,
           ALUSrc, Mem2Reg, ALUop, trap, state, instret
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32-subset sequencer: one shared memory port, memReady handshake,
// interrupt redirect at retire, illegal-opcode / memory-timeout trap.
//
// state  | meaning
// RST    | load PC with entryPoint
// FETCH  | read instruction, wait memReady, load IR
// DECODE | classify opcode; UJ retires here
// EXEC   | ALU step; SB retires here
// MEM    | data read/write, wait memReady; S retires here
// WB     | register file write, retire
// TRAP   | redirect to entryPoint, pulse trap
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input logic             clk,
  input logic             rst_n,
  multicycle_ctrl_if.master bus
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_SB = 7'b1100011;
  localparam logic [6:0] OP_UJ = 7'b1101111;

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              int_pend_q, int_pend_d;
  logic              retire;

  logic       is_lw, is_s, alu_src;
  logic [1:0] alu_op;

  assign is_lw   = (bus.opCode == OP_LW);
  assign is_s    = (bus.opCode == OP_S);
  assign alu_src = (bus.opCode == OP_LW) || (bus.opCode == OP_I) || (bus.opCode == OP_S);
  assign alu_op  = (bus.opCode == OP_R)  ? 2'b10 :
                   (bus.opCode == OP_SB) ? 2'b01 : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RST;
      wait_q     <= '0;
      instret_q  <= '0;
      int_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      instret_q  <= instret_d;
      int_pend_q <= int_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    retire       = 1'b0;
    bus.PCWrite  = 1'b0;
    bus.PCSel    = 2'd0;
    bus.IRWrite  = 1'b0;
    bus.IorD     = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.RegWrite = 1'b0;
    bus.ALUSrc   = 1'b0;
    bus.Mem2Reg  = 1'b0;
    bus.ALUop    = 2'b00;
    bus.trap     = 1'b0;

    case (state_q)
      S_RST: begin
        bus.PCWrite = 1'b1;
        bus.PCSel   = 2'd3;
        state_d     = S_FETCH;
      end
      S_FETCH: begin
        bus.MemRead = 1'b1;
        if (bus.memReady) begin
          bus.IRWrite = 1'b1;
          state_d     = S_DECODE;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        case (bus.opCode)
          OP_UJ: begin
            retire      = 1'b1;
            bus.PCWrite = 1'b1;
            bus.PCSel   = 2'd2;
            state_d     = S_FETCH;
          end
          OP_LW, OP_I, OP_R, OP_S, OP_SB: state_d = S_EXEC;
          default:                        state_d = S_TRAP;
        endcase
      end
      S_EXEC: begin
        bus.ALUSrc = alu_src;
        bus.ALUop  = alu_op;
        case (bus.opCode)
          OP_R, OP_I:   state_d = S_WB;
          OP_LW, OP_S:  state_d = S_MEM;
          OP_SB: begin
            retire      = 1'b1;
            bus.PCWrite = 1'b1;
            bus.PCSel   = bus.zero ? 2'd1 : 2'd0;
            state_d     = S_FETCH;
          end
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        bus.IorD     = 1'b1;
        bus.ALUSrc   = alu_src;
        bus.ALUop    = alu_op;
        bus.MemRead  = is_lw;
        bus.MemWrite = is_s;
        if (bus.memReady) begin
          if (is_lw) begin
            state_d = S_WB;
          end else begin
            retire      = 1'b1;
            bus.PCWrite = 1'b1;
            state_d     = S_FETCH;
          end
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        bus.RegWrite = 1'b1;
        bus.Mem2Reg  = is_lw;
        bus.ALUSrc   = alu_src;
        bus.ALUop    = alu_op;
        retire       = 1'b1;
        bus.PCWrite  = 1'b1;
        state_d      = S_FETCH;
      end
      S_TRAP: begin
        bus.trap    = 1'b1;
        bus.PCWrite = 1'b1;
        bus.PCSel   = 2'd3;
        state_d     = S_FETCH;
      end
      default: state_d = S_RST;
    endcase

    // Any state change restarts the memory wait budget.
    if (state_d != state_q) wait_d = '0;

    if (retire && (int_pend_q || bus.INT)) bus.PCSel = 2'd3;

    // Strobes are forced low for the whole reset assertion, not just after the edge.
    if (!rst_n) begin
      bus.PCWrite  = 1'b0;
      bus.PCSel    = 2'd0;
      bus.IRWrite  = 1'b0;
      bus.IorD     = 1'b0;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.RegWrite = 1'b0;
      bus.ALUSrc   = 1'b0;
      bus.Mem2Reg  = 1'b0;
      bus.ALUop    = 2'b00;
      bus.trap     = 1'b0;
    end
  end

  always_comb begin
    int_pend_d = int_pend_q;
    if (bus.INT && (state_q != S_RST)) int_pend_d = 1'b1;
    if (retire || (state_q == S_TRAP)) int_pend_d = 1'b0;
  end

  assign instret_d   = retire ? instret_q + CNT_W'(1) : instret_q;
  assign bus.state   = state_q;
  assign bus.instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction classes, memory waits, traps,
// interrupt redirect, counter wrap and mid-instruction reset.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   ncmp = 0;
  int   nerr = 0;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(32)) a_if ();
  multicycle_ctrl_if #(.CNT_W(4))  b_if ();

  multicycle_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.master));
  multicycle_ctrl #(.TIMEOUT(4),  .CNT_W(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.master));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    a_if.opCode = ADDI; a_if.zero = 1'b0; a_if.INT = 1'b0; a_if.memReady = 1'b1;
    b_if.opCode = ADDI; b_if.zero = 1'b0; b_if.INT = 1'b0; b_if.memReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", a_if.state, 0);
    chk("rst_pcwrite_gated", a_if.PCWrite, 0);
    chk("rst_pcsel_gated", a_if.PCSel, 0);
    chk("rst_instret", a_if.instret, 0);

    // addi with memReady tied high: 0,1,2,3,5,1
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rel_state", a_if.state, 0);
    chk("rel_pcwrite", a_if.PCWrite, 1);
    chk("rel_pcsel", a_if.PCSel, 3);
    tick();
    chk("addi_fetch_state", a_if.state, 1);
    chk("addi_fetch_memread", a_if.MemRead, 1);
    chk("addi_fetch_irwrite", a_if.IRWrite, 1);
    chk("addi_fetch_iord", a_if.IorD, 0);
    tick(); chk("addi_decode_state", a_if.state, 2);
    tick(); chk("addi_exec_state", a_if.state, 3);
    chk("addi_exec_alusrc", a_if.ALUSrc, 1);
    chk("addi_exec_aluop", a_if.ALUop, 0);
    tick(); chk("addi_wb_state", a_if.state, 5);
    chk("addi_wb_regwrite", a_if.RegWrite, 1);
    chk("addi_wb_alusrc", a_if.ALUSrc, 1);
    chk("addi_wb_mem2reg", a_if.Mem2Reg, 0);
    chk("addi_wb_pcsel", a_if.PCSel, 0);
    tick(); chk("addi_next_state", a_if.state, 1);
    chk("addi_instret", a_if.instret, 1);

    // lw with three not-ready cycles in MEM
    a_if.opCode = LW;
    tick(); chk("lw_decode", a_if.state, 2);
    tick(); chk("lw_exec", a_if.state, 3);
    a_if.memReady = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) a_if.memReady = 1'b1;
      #1;
      chk("lw_mem_state", a_if.state, 4);
      chk("lw_mem_memread", a_if.MemRead, 1);
      chk("lw_mem_iord", a_if.IorD, 1);
      chk("lw_mem_memwrite", a_if.MemWrite, 0);
      tick();
    end
    chk("lw_wb_state", a_if.state, 5);
    chk("lw_wb_mem2reg", a_if.Mem2Reg, 1);
    chk("lw_wb_regwrite", a_if.RegWrite, 1);
    tick(); chk("lw_instret", a_if.instret, 2);

    // sw with three not-ready cycles in MEM
    a_if.opCode = SW;
    tick(); tick(); chk("sw_exec", a_if.state, 3);
    a_if.memReady = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) a_if.memReady = 1'b1;
      #1;
      chk("sw_mem_state", a_if.state, 4);
      chk("sw_mem_memwrite", a_if.MemWrite, 1);
      chk("sw_mem_memread", a_if.MemRead, 0);
      chk("sw_mem_pcwrite", a_if.PCWrite, (i == 3) ? 1 : 0);
      tick();
    end
    chk("sw_next_state", a_if.state, 1);
    chk("sw_instret", a_if.instret, 3);

    // beq taken / not taken, then jal
    a_if.opCode = BEQ; a_if.zero = 1'b1;
    tick(); tick();
    chk("beq1_state", a_if.state, 3);
    chk("beq1_aluop", a_if.ALUop, 1);
    chk("beq1_alusrc", a_if.ALUSrc, 0);
    chk("beq1_pcwrite", a_if.PCWrite, 1);
    chk("beq1_pcsel", a_if.PCSel, 1);
    tick(); chk("beq1_next", a_if.state, 1);
    a_if.zero = 1'b0;
    tick(); tick();
    chk("beq0_pcsel", a_if.PCSel, 0);
    tick(); chk("beq_instret", a_if.instret, 5);
    a_if.opCode = JAL;
    tick();
    chk("jal_decode_pcsel", a_if.PCSel, 2);
    chk("jal_decode_pcwrite", a_if.PCWrite, 1);
    tick(); chk("jal_next_state", a_if.state, 1);
    chk("jal_instret", a_if.instret, 6);

    // illegal opcode
    a_if.opCode = 7'b1111111;
    tick(); chk("ill_decode_pcwrite", a_if.PCWrite, 0);
    tick(); chk("ill_trap_state", a_if.state, 6);
    chk("ill_trap", a_if.trap, 1);
    chk("ill_trap_pcsel", a_if.PCSel, 3);
    tick(); chk("ill_trap_pulse", a_if.trap, 0);
    chk("ill_instret", a_if.instret, 6);

    // interrupt pulse during EXEC of an R-type
    a_if.opCode = RT;
    tick(); tick();
    a_if.INT = 1'b1; #1;
    chk("int_exec_state", a_if.state, 3);
    chk("int_exec_aluop", a_if.ALUop, 2);
    tick(); a_if.INT = 1'b0; #1;
    chk("int_wb_state", a_if.state, 5);
    chk("int_wb_regwrite", a_if.RegWrite, 1);
    chk("int_wb_pcsel", a_if.PCSel, 3);
    tick(); chk("int_instret", a_if.instret, 7);
    a_if.opCode = ADDI;
    tick(); tick(); tick();
    chk("post_int_wb_pcsel", a_if.PCSel, 0);
    tick(); chk("post_int_instret", a_if.instret, 8);

    // reset mid-MEM while MemWrite is high
    a_if.opCode = SW;
    tick(); tick();
    a_if.memReady = 1'b0;
    tick(); chk("mrst_memwrite_before", a_if.MemWrite, 1);
    #2 rst_n = 1'b0; #1;
    chk("mrst_memwrite", a_if.MemWrite, 0);
    chk("mrst_state", a_if.state, 0);
    chk("mrst_instret", a_if.instret, 0);
    a_if.memReady = 1'b1;

    // CNT_W=4 wrap after 16 addi retires
    @(negedge clk); rst_n = 1'b1;
    tick(); chk("b_fetch", b_if.state, 1);
    for (int i = 0; i < 16; i++) begin
      tick(); tick(); tick(); tick();
      chk("b_instret", b_if.instret, (i + 1) % 16);
    end

    // TIMEOUT=4: memReady stuck low in FETCH
    b_if.memReady = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      chk("b_to_state", b_if.state, 1);
      chk("b_to_irwrite", b_if.IRWrite, 0);
      tick();
    end
    chk("b_to_trap_state", b_if.state, 6);
    chk("b_to_trap", b_if.trap, 1);
    tick(); chk("b_to_trap_pulse", b_if.trap, 0);
    chk("b_to_instret", b_if.instret, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
